// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants, colour and status types for the floor renderer
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  typedef struct packed {
    logic [3:0] floor;
    logic door;
    logic up;
    logic dn;
  } status_t;
  localparam rgb_t C_BLACK = 12'h000;
  localparam rgb_t C_CUR = 12'h0F0;
  localparam rgb_t C_DOOR = 12'hFF0;
  localparam rgb_t C_IDLE = 12'h444;
  localparam rgb_t C_LIT = 12'hFFF;
  localparam rgb_t C_DIM = 12'h222;
endpackage

// File: rtl/vga_cell_tracker.sv
// vga_cell_tracker: follows which floor cell and cell line the beam is on without dividing pix_y
module vga_cell_tracker import vga_pkg::*; #(
  parameter int NUM_FLOORS = 8,
  parameter int CELL_H = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [3:0] cell_idx,
  output logic       gap,
  output logic       below_cells
);
  localparam int LW = CELL_H > 1 ? $clog2(CELL_H) : 1;
  logic [LW-1:0] cell_line;
  always_ff @(posedge clk)
    if (reset) begin
      cell_idx <= 4'(NUM_FLOORS - 1);
      cell_line <= '0;
    end else if (pix_x == 10'(H_ACTIVE)) begin
      if (pix_y == 10'(V_TOTAL - 1)) begin
        cell_idx <= 4'(NUM_FLOORS - 1);
        cell_line <= '0;
      end else if (cell_line == LW'(CELL_H - 1)) begin
        cell_line <= '0;
        cell_idx <= cell_idx == 4'd0 ? cell_idx : cell_idx - 4'd1;
      end else begin
        cell_line <= cell_line + LW'(1);
      end
    end
  assign gap = cell_line == LW'(CELL_H - 1);
  assign below_cells = pix_y >= 10'(NUM_FLOORS * CELL_H);
endmodule

// File: rtl/vga_floor_renderer.sv
// vga_floor_renderer: draws the elevator floor column and direction boxes, 2-cycle aligned with syncs
module vga_floor_renderer import vga_pkg::*; #(
  parameter int NUM_FLOORS = 8,
  parameter int CELL_H = 60,
  parameter int COL_X0 = 280,
  parameter int COL_W = 80,
  parameter int ARROW_X0 = 400,
  parameter int ARROW_W = 40,
  parameter int BLINK_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       video_active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       status_valid,
  input  logic [3:0] floor_num,
  input  logic       door_open,
  input  logic       dir_up,
  input  logic       dir_down,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);
  status_t inc, pend, disp;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic legal, boundary, gap, below_cells;
  logic [3:0] cell_idx, s1_idx;
  logic s1_col, s1_up, s1_dn, s1_gap, s1_below, s1_act, s1_hs, s1_vs;
  rgb_t c, px;
  vga_cell_tracker #(.NUM_FLOORS(NUM_FLOORS), .CELL_H(CELL_H)) u_tracker (
    .clk(clk),
    .reset(reset),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .cell_idx(cell_idx),
    .gap(gap),
    .below_cells(below_cells)
  );
  assign inc = {floor_num, door_open, dir_up, dir_down};
  assign legal = status_valid && {1'b0, floor_num} < 5'(NUM_FLOORS);
  assign boundary = pix_x == 10'd0 && pix_y == 10'(V_ACTIVE);
  // display only changes in vertical blank, so a frame is never drawn from mixed status
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      disp <= '0;
      frame_cnt <= '0;
    end else begin
      if (legal) pend <= inc;
      if (boundary) begin
        disp <= legal ? inc : pend;
        frame_cnt <= frame_cnt + BLINK_LOG2'(1);
      end
    end
  always_ff @(posedge clk)
    if (reset) begin
      {s1_col, s1_up, s1_dn, s1_gap, s1_below, s1_act} <= '0;
      s1_idx <= '0;
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
    end else begin
      s1_col <= pix_x >= 10'(COL_X0) && pix_x < 10'(COL_X0 + COL_W);
      s1_up <= pix_x >= 10'(ARROW_X0) && pix_x < 10'(ARROW_X0 + ARROW_W) && cell_idx == 4'(NUM_FLOORS - 1);
      s1_dn <= pix_x >= 10'(ARROW_X0) && pix_x < 10'(ARROW_X0 + ARROW_W) && cell_idx == 4'd0;
      s1_gap <= gap;
      s1_below <= below_cells;
      s1_idx <= cell_idx;
      s1_act <= video_active;
      s1_hs <= hsync_in;
      s1_vs <= vsync_in;
    end
  always_comb
    c = !s1_act || s1_gap || s1_below ? C_BLACK :
        s1_col && s1_idx == disp.floor ? (disp.door && frame_cnt[BLINK_LOG2-1] ? C_DOOR : C_CUR) :
        s1_col ? C_IDLE :
        s1_up ? (disp.up ? C_LIT : C_DIM) :
        s1_dn ? (disp.dn ? C_LIT : C_DIM) : C_BLACK;
  always_ff @(posedge clk)
    if (reset) begin
      px <= C_BLACK;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      px <= c;
      hsync <= s1_hs;
      vsync <= s1_vs;
    end
  assign red = px.r;
  assign green = px.g;
  assign blue = px.b;
endmodule

// File: tb/tb_vga_floor_renderer.sv
// tb_vga_floor_renderer: directed frame renders plus a random latency stream with assertion checks
module tb_vga_floor_renderer;
  logic clk = 0, reset = 1;
  logic [9:0] pix_x = 0, pix_y = 0;
  logic video_active = 0, hsync_in = 1, vsync_in = 1;
  logic status_valid = 0, door_open = 0, dir_up = 0, dir_down = 0;
  logic [3:0] floor_num = 0;
  logic hsync, vsync;
  logic [3:0] red, green, blue;
  logic [11:0] rgb, ra, rb;
  int total = 0, passes = 0, fc = 0;
  assign rgb = {red, green, blue};
  always #20 clk = ~clk;
  vga_floor_renderer dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .status_valid(status_valid), .floor_num(floor_num),
    .door_open(door_open), .dir_up(dir_up), .dir_down(dir_down), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue)
  );
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed %h expected %h", tag, obs, exp);
  endtask
  task automatic drive(input int x, input int y, input bit act);
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_active = act;
    @(posedge clk);
    #1;
  endtask
  task automatic strobe(input int f, input bit d, input bit u, input bit n);
    {floor_num, door_open, dir_up, dir_down} = {4'(f), d, u, n};
    status_valid = 1;
    drive(700, 200, 0);
    status_valid = 0;
  endtask
  // one compressed frame: per line x=0, the probe column, then the tracker tick at x=640
  task automatic render(input int px, input int ya, input int yb, output logic [11:0] oa, output logic [11:0] ob);
    oa = 'x;
    ob = 'x;
    for (int y = 0; y < 525; y++) begin
      drive(0, y, y < 480);
      drive(px, y, y < 480 && px < 640);
      drive(640, y, 0);
      if (y == ya) oa = rgb;
      if (y == yb) ob = rgb;
    end
    fc++;
  endtask
  task automatic skip_frame();
    drive(0, 480, 0);
    drive(640, 524, 0);
    fc++;
  endtask
  function automatic logic [11:0] model_top(input int x, input bit act);
    if (!act) return 12'h000;
    if (x >= 280 && x < 360) return 12'h444;
    if (x >= 400 && x < 440) return 12'h222;
    return 12'h000;
  endfunction
  initial begin
    int xp;
    bit ap, hp, vp;
    hsync_in = 0;
    vsync_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_sync", {10'd0, hsync, vsync}, 12'h003);
    reset = 0;
    hsync_in = 1;
    vsync_in = 1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1);
      check("post_rst_rgb", rgb, 12'h000);
      check("post_rst_sync", {10'd0, hsync, vsync}, 12'h003);
    end
    strobe(3, 0, 0, 0);
    render(300, 270, 90, ra, rb);
    check("held_270", ra, 12'h444);
    check("held_90", rb, 12'h444);
    render(300, 270, 90, ra, rb);
    check("cur_270", ra, 12'h0F0);
    check("idle_90", rb, 12'h444);
    strobe(0, 1, 0, 0);
    render(300, 450, 479, ra, rb);
    check("old_450", ra, 12'h444);
    check("gap_479a", rb, 12'h000);
    render(300, 450, 479, ra, rb);
    check("door_f3", ra, 12'h0F0);
    check("gap_479b", rb, 12'h000);
    while (fc < 16) skip_frame();
    render(300, 450, 479, ra, rb);
    check("door_f16", ra, 12'hFF0);
    check("gap_479c", rb, 12'h000);
    while (fc < 32) skip_frame();
    render(300, 450, 479, ra, rb);
    check("door_f32", ra, 12'h0F0);
    strobe(9, 0, 1, 1);
    render(300, 450, 479, ra, rb);
    check("bad_floor_a", ra, 12'h0F0);
    render(300, 450, 479, ra, rb);
    check("bad_floor_b", ra, 12'h0F0);
    render(410, 10, 430, ra, rb);
    check("bad_up", ra, 12'h222);
    check("bad_dn", rb, 12'h222);
    strobe(5, 0, 1, 0);
    render(410, 10, 430, ra, rb);
    check("up_old", ra, 12'h222);
    render(410, 10, 430, ra, rb);
    check("up_lit", ra, 12'hFFF);
    check("dn_dim", rb, 12'h222);
    strobe(5, 0, 1, 1);
    render(410, 10, 430, ra, rb);
    check("dn_old", rb, 12'h222);
    render(410, 10, 430, ra, rb);
    check("both_up", ra, 12'hFFF);
    check("both_dn", rb, 12'hFFF);
    {floor_num, door_open, dir_up, dir_down} = {4'd2, 1'b0, 1'b0, 1'b1};
    status_valid = 1;
    drive(0, 480, 0);
    status_valid = 0;
    drive(640, 524, 0);
    fc++;
    render(300, 330, 90, ra, rb);
    check("bnd_cur", ra, 12'h0F0);
    check("bnd_idle", rb, 12'h444);
    render(410, 10, 430, ra, rb);
    check("bnd_up", ra, 12'h222);
    check("bnd_dn", rb, 12'hFFF);
    xp = 0;
    ap = 0;
    hp = 1;
    vp = 1;
    for (int i = 0; i < 300; i++) begin
      int x;
      bit a, h, v;
      x = $urandom_range(639, 0);
      a = 1'($urandom);
      h = 1'($urandom);
      v = 1'($urandom);
      hsync_in = h;
      vsync_in = v;
      drive(x, $urandom_range(479, 0), a);
      if (i > 0) begin
        check("rnd_rgb", rgb, model_top(xp, ap));
        check("rnd_sync", {10'd0, hsync, vsync}, {10'd0, hp, vp});
      end
      xp = x;
      ap = a;
      hp = h;
      vp = v;
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
